// File: rtl/instr_assembler.sv
// Fetch-side instruction assembler: predecodes 6502/65C02 length, gathers bytes, FIFO-buffers.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data/in_pc, out_valid/out_ready/out_opcode/out_operand/out_len/out_pc/out_jam.
module instr_assembler #(
  parameter int DEPTH  = 4,
  parameter int CMOS   = 0,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_opcode,
  output logic [15:0]       out_operand,
  output logic [1:0]        out_len,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_jam
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [7:0]        opcode;
    logic [15:0]       operand;
    logic [1:0]        len;
    logic [ADDR_W-1:0] pc;
    logic              jam;
  } entry_t;

  typedef enum logic [1:0] {
    S_OPC,
    S_OP1,
    S_OP2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [7:0]        opc_q;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        len_q;
  logic              jam_q;
  logic [7:0]        lo_q;

  entry_t            mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic [1:0]        dec_len;
  logic              dec_jam;
  logic              xfer_in;
  logic              push;
  logic              pop;
  entry_t            entry;
  entry_t            head;

  assign in_ready  = rst_n && (count < FULL);
  assign out_valid = (count != '0);
  assign xfer_in   = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    dec_len = 2'd2;
    dec_jam = 1'b0;
    if (in_data == 8'h00 || in_data == 8'h40 ||
        in_data == 8'h60 ||
        (in_data[3:2] == 2'b10 && !in_data[0])) begin
      dec_len = 2'd1;
    end else if (CMOS == 0 &&
                 ((!in_data[7] && in_data[4:0] == 5'b00010) ||
                  in_data[4:0] == 5'b10010)) begin
      dec_len = 2'd1;
      dec_jam = 1'b1;
    end else if (in_data == 8'h20 ||
                 in_data[4:2] == 3'b011 ||
                 (in_data[4:2] == 3'b110 && in_data[0]) ||
                 in_data[4:2] == 3'b111) begin
      dec_len = 2'd3;
    end
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    entry      = '0;
    unique case (state)
      S_OPC: begin
        if (xfer_in) begin
          if (dec_len == 2'd1) begin
            push  = 1'b1;
            entry = '{in_data, 16'h0000, 2'd1, in_pc, dec_jam};
          end else begin
            next_state = S_OP1;
          end
        end
      end
      S_OP1: begin
        if (xfer_in) begin
          if (len_q == 2'd2) begin
            push       = 1'b1;
            entry      = '{opc_q, {8'h00, in_data}, 2'd2, pc_q, jam_q};
            next_state = S_OPC;
          end else begin
            next_state = S_OP2;
          end
        end
      end
      S_OP2: begin
        if (xfer_in) begin
          push       = 1'b1;
          entry      = '{opc_q, {in_data, lo_q}, 2'd3, pc_q, jam_q};
          next_state = S_OPC;
        end
      end
      default: next_state = S_OPC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OPC;
    end else if (flush) begin
      state <= S_OPC;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= '0;
      pc_q  <= '0;
      len_q <= '0;
      jam_q <= 1'b0;
      lo_q  <= '0;
    end else begin
      if (xfer_in && state == S_OPC) begin
        opc_q <= in_data;
        pc_q  <= in_pc;
        len_q <= dec_len;
        jam_q <= dec_jam;
      end
      if (xfer_in && state == S_OP1) begin
        lo_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry comes straight from the storage flops; reset clears them,
  // so all head fields read zero while rst_n is low.
  assign head        = mem[rd_ptr];
  assign out_opcode  = head.opcode;
  assign out_operand = head.operand;
  assign out_len     = head.len;
  assign out_pc      = head.pc;
  assign out_jam     = head.jam;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: NMOS instance plus a CMOS instance.
// Checks stream assembly, backpressure, flush, JAM/CMOS lengths, async reset, push+pop.
module tb_instr_assembler;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [15:0] out_operand;
  logic [1:0]  out_len;
  logic [15:0] out_pc;
  logic        out_jam;

  logic        c_valid;
  logic        c_in_ready;
  logic        c_out_valid;
  logic        c_out_ready;
  logic [7:0]  c_opcode;
  logic [15:0] c_operand;
  logic [1:0]  c_len;
  logic [15:0] c_pc;
  logic        c_jam;

  int n_tests;
  int n_fail;

  instr_assembler #(.DEPTH(4), .CMOS(0), .ADDR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_operand(out_operand),
    .out_len(out_len), .out_pc(out_pc), .out_jam(out_jam)
  );

  instr_assembler #(.DEPTH(4), .CMOS(1), .ADDR_W(16)) u_cmos (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(c_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_pc(in_pc),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_opcode(c_opcode), .out_operand(c_operand),
    .out_len(c_len), .out_pc(c_pc), .out_jam(c_jam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [15:0] pc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_pc    = pc;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_c(input logic [7:0] b, input logic [15:0] pc);
    int n;
    n = 0;
    c_valid = 1'b1;
    in_data = b;
    in_pc   = pc;
    while (!c_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sendc_rdy", c_in_ready, 1);
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag,
                           input logic [7:0]  opc,
                           input logic [15:0] opnd,
                           input logic [1:0]  len,
                           input logic [15:0] pc,
                           input logic        jam);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_opc"}, out_opcode, opc);
    check({tag, "_opnd"}, out_operand, opnd);
    check({tag, "_len"}, out_len, len);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_jam"}, out_jam, jam);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] seq [10];

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_pc       = 16'h0000;
    out_ready   = 1'b0;
    c_valid     = 1'b0;
    c_out_ready = 1'b0;
    seq = '{8'h88, 8'hCA, 8'h18, 8'h38, 8'h58,
            8'h78, 8'hB8, 8'hD8, 8'hF8, 8'hEA};

    // reset state
    @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_rdy", in_ready, 0);
    check("rst_opc", out_opcode, 0);
    check("rst_len", out_len, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", in_ready, 1);

    // basic stream
    send(8'hA9, 16'h0200);
    send(8'h05, 16'h0201);
    check("lat1_vld", out_valid, 1);
    send(8'h8D, 16'h0202);
    send(8'h00, 16'h0203);
    send(8'h02, 16'h0204);
    send(8'hEA, 16'h0205);
    pop_check("lda", 8'hA9, 16'h0005, 2'd2, 16'h0200, 1'b0);
    pop_check("sta", 8'h8D, 16'h0200, 2'd3, 16'h0202, 1'b0);
    pop_check("nop", 8'hEA, 16'h0000, 2'd1, 16'h0205, 1'b0);
    check("s1_empty", out_valid, 0);

    // backpressure
    for (int i = 0; i < 4; i++) send(8'hE8, 16'h0300 + 16'(i));
    check("full_rdy", in_ready, 0);
    for (int i = 0; i < 4; i++)
      pop_check("bp_a", 8'hE8, 16'h0000, 2'd1, 16'h0300 + 16'(i), 1'b0);
    for (int i = 4; i < 8; i++) send(8'hE8, 16'h0300 + 16'(i));
    check("full2_rdy", in_ready, 0);
    for (int i = 4; i < 8; i++)
      pop_check("bp_b", 8'hE8, 16'h0000, 2'd1, 16'h0300 + 16'(i), 1'b0);
    check("bp_empty", out_valid, 0);

    // flush with byte presented
    send(8'hEA, 16'h03F0);
    send(8'h4C, 16'h0400);
    send(8'h34, 16'h0401);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h12;
    in_pc    = 16'h0402;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_vld", out_valid, 0);
    send(8'h60, 16'h0410);
    pop_check("rts", 8'h60, 16'h0000, 2'd1, 16'h0410, 1'b0);
    check("fl_empty", out_valid, 0);

    // JAM and CMOS lengths
    send(8'h02, 16'h0500);
    pop_check("jam", 8'h02, 16'h0000, 2'd1, 16'h0500, 1'b1);
    send(8'hA2, 16'h0510);
    send(8'h07, 16'h0511);
    pop_check("ldx", 8'hA2, 16'h0007, 2'd2, 16'h0510, 1'b0);
    send_c(8'h12, 16'h0520);
    send_c(8'h80, 16'h0521);
    check("c_vld", c_out_valid, 1);
    check("c_opc", c_opcode, 8'h12);
    check("c_opnd", c_operand, 16'h0080);
    check("c_len", c_len, 2'd2);
    check("c_pc", c_pc, 16'h0520);
    check("c_jam", c_jam, 0);
    c_out_ready = 1'b1;
    @(negedge clk);
    c_out_ready = 1'b0;
    check("c_empty", c_out_valid, 0);

    // async reset mid-instruction
    send(8'hEA, 16'h05F0);
    send(8'h20, 16'h0600);
    send(8'h00, 16'h0601);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", out_valid, 0);
    check("ar_rdy", in_ready, 0);
    check("ar_opc", out_opcode, 0);
    check("ar_pc", out_pc, 0);
    check("ar_len", out_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_rel", in_ready, 1);
    @(negedge clk);
    send(8'h18, 16'h0700);
    pop_check("clc", 8'h18, 16'h0000, 2'd1, 16'h0700, 1'b0);
    check("ar_empty", out_valid, 0);

    // simultaneous push and pop at count 2
    send(8'hE8, 16'h0800);
    send(8'hC8, 16'h0801);
    exp_q.push_back(8'hE8);
    exp_q.push_back(8'hC8);
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_data   = seq[i];
      in_pc     = 16'h0810 + 16'(i);
      out_ready = 1'b1;
      check("pp_rdy", in_ready, 1);
      check("pp_opc", out_opcode, exp_q.pop_front());
      exp_q.push_back(seq[i]);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pop_check("pp_d0", 8'hF8, 16'h0000, 2'd1, 16'h0818, 1'b0);
    pop_check("pp_d1", 8'hEA, 16'h0000, 2'd1, 16'h0819, 1'b0);
    check("pp_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Parametrised fetch-side successor to the combinational opcode decoder.
- Accepts the raw byte stream from the memory fetch path and predecodes instruction length from the opcode.
- Gathers the opcode plus 0–2 operand bytes into complete instructions and buffers them in a DEPTH-entry FIFO for the execute/decode stage.
- Handles valid/ready handshakes on both sides, flush on control-flow change, and an NMOS/CMOS (65C02) opcode-length mode.

Parameters:
- DEPTH, 4: number of complete-instruction FIFO entries; must be ≥2 and a power of 2.
- CMOS, 0: 0 = NMOS 6502 length/JAM rules; 1 = 65C02 length rules, no JAM.
- ADDR_W, 16: width of the program-counter tag.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all buffered and partial state.
- in_valid  in  1  fetch byte valid.
- in_ready  out  1  block can accept a byte.
- in_data  in  8  fetched byte.
- in_pc  in  ADDR_W  address of in_data; sampled only on opcode bytes.
- out_valid  out  1  head instruction valid.
- out_ready  in  1  consumer accepts head instruction.
- out_opcode  out  8  head opcode.
- out_operand  out  16  head operand: {hi,lo}; 2-byte instr = {8'h00,lo}; 1-byte instr = 0.
- out_len  out  2  instruction length, 1..3.
- out_pc  out  ADDR_W  address of the opcode byte.
- out_jam  out  1  head opcode is a JAM/KIL opcode (NMOS only).

Behaviour:
- Reset (rst_n low, async):
  - FIFO empty, count=0, assembler in S_OPC.
  - out_valid=0, in_ready=0 while rst_n low, in_ready=1 the first cycle after release.
  - out_opcode/out_operand/out_pc/out_len/out_jam=0.
- Byte transfer: in_valid&&in_ready. Instruction transfer: out_valid&&out_ready.
- Length predecode on the opcode byte, evaluated in priority order:
  - 1-byte: opcode 8'h00, 8'h40, 8'h60, or ??? ?10 ?0.
  - JAM: NMOS only, 0??_000_10 or ???_100_10 → length 1, jam=1.
  - 3-byte: 8'h20, ???_011_??, ???_110_?1, ???_111_??.
  - CMOS=1: ???_100_10 is 2-byte (zp indirect); ??? 000_10 is 2-byte NOP imm.
  - Else 2-byte.
- Assembler FSM:
  - S_OPC: on byte transfer, latch opcode, pc, len and jam. len=1 → push; else go to S_OP1.
  - S_OP1: on transfer, latch lo. len=2 → push, go to S_OPC; else go to S_OP2.
  - S_OP2: on transfer, latch hi, push, go to S_OPC.
  - No transfer: hold state.
- in_ready = rst_n && (count<DEPTH). Strict: a pop in the same cycle does not free a slot for that cycle (no bypass).
- Push occurs in the cycle the final byte transfers; out_valid for that entry is visible the next cycle. Minimum latency from last byte to out_valid is 1 cycle.
- FIFO:
  - Registered read head; wr/rd pointers wrap modulo DEPTH.
  - Count width $clog2(DEPTH+1).
  - Simultaneous push and pop leaves count unchanged.
  - out_valid = count!=0. Outputs are stable while out_valid&&!out_ready.
- flush (highest priority):
  - Next edge: count=0, pointers=0, FSM=S_OPC, partial instruction discarded.
  - Any byte or instruction transfer in the flush cycle is ignored (no push, no pop counted).
  - out_valid=0 the cycle after flush; the next accepted byte is treated as an opcode.
- Reset mid-instruction returns to S_OPC immediately and discards the partial instruction.
- Bytes in S_OP1/S_OP2 are not checked against pc continuity; in_pc is ignored there.

Test Plan:
- NMOS: stream A9 05 8D 00 02 EA at pc 0x0200.., out_ready=1 → three outputs:
  - {A9, 0x0005, len2, pc0200}
  - {8D, 0x0200, len3, pc0202}
  - {EA, 0x0000, len1, pc0205}
- out_ready=0, DEPTH=4, stream eight 1-byte opcodes E8 → in_ready falls after the 4th byte. Release out_ready → outputs in order, no loss or duplication, count returns to 0.
- Send 4C 34 then assert flush with byte 12 presented → 12 not accepted. Then send 60 → single output {60, len1}; no 4C entry ever appears.
- NMOS: byte 02 → out_jam=1, len1. CMOS=1: bytes 12 80 → {12, 0x0080, len2, jam0}.
- Pulse rst_n low during S_OP2 of 20 00 .. → all outputs 0 asynchronously. After release, 18 → {18, len1}.
- Simultaneous push and pop at count=2 for 10 cycles → count stays 2, data ordering preserved.
